// File: rtl/pipeline_control.sv
// Hazard and stall controller for a five-stage pipeline: drives PC and latch
// enable/flush pairs, tracks a sticky halt and saturating stall/flush counters.
module pipeline_control (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_jump,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_wsel,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_branch_taken,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        fetch_en,
    output logic        fetch_flush,
    output logic        decode_en,
    output logic        decode_flush,
    output logic        exec_en,
    output logic        exec_flush,
    output logic        mem_en,
    output logic        mem_flush,
    output logic        halt,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        DMEM_WAIT  = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;
    logic        w_stall_inc;
    logic        w_flush_inc;
    logic        w_dmem_busy;
    logic        w_load_use;

    // DMEM_WAIT keeps waiting on dhit even if the memory stage request drops.
    assign w_dmem_busy = ((r_state == DMEM_WAIT) | mem_dREN | mem_dWEN) & ~dhit;

    // The bubble sitting in execute after a load stall must not re-trigger.
    assign w_load_use  = (r_state != LOAD_STALL) & ex_dREN & (ex_wsel != 5'd0)
                       & ((ex_wsel == id_rs) | (ex_wsel == id_rt));

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        pc_en        = 1'b0;
        fetch_en     = 1'b0;
        fetch_flush  = 1'b0;
        decode_en    = 1'b0;
        decode_flush = 1'b0;
        exec_en      = 1'b0;
        exec_flush   = 1'b0;
        mem_en       = 1'b0;
        mem_flush    = 1'b0;

        // A flushed latch always has its enable low, so flush wins at every latch.
        if (!nRST) begin
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
            exec_flush   = 1'b1;
            mem_flush    = 1'b1;
        end else if (r_state == HALTED) begin
            w_next_state = HALTED;
        end else if (wb_halt) begin
            w_next_state = HALTED;
        end else if (w_dmem_busy) begin
            w_next_state = DMEM_WAIT;
            w_stall_inc  = 1'b1;
        end else if (mem_branch_taken) begin
            w_next_state = RUN;
            pc_en        = 1'b1;
            fetch_flush  = 1'b1;
            decode_flush = 1'b1;
            exec_flush   = 1'b1;
            mem_en       = 1'b1;
            w_flush_inc  = 1'b1;
        end else if (w_load_use) begin
            w_next_state = LOAD_STALL;
            decode_flush = 1'b1;
            exec_en      = 1'b1;
            mem_en       = 1'b1;
            w_stall_inc  = 1'b1;
        end else if (id_jump && ihit) begin
            // A jump only redirects once its own fetch has completed.
            w_next_state = RUN;
            pc_en        = 1'b1;
            fetch_flush  = 1'b1;
            decode_en    = 1'b1;
            exec_en      = 1'b1;
            mem_en       = 1'b1;
            w_flush_inc  = 1'b1;
        end else if (!ihit) begin
            w_next_state = RUN;
            fetch_flush  = 1'b1;
            decode_en    = 1'b1;
            exec_en      = 1'b1;
            mem_en       = 1'b1;
            w_stall_inc  = 1'b1;
        end else begin
            w_next_state = RUN;
            pc_en        = 1'b1;
            fetch_en     = 1'b1;
            decode_en    = 1'b1;
            exec_en      = 1'b1;
            mem_en       = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (!nRST) begin
            r_state       <= RUN;
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_stall_inc && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
            if (w_flush_inc && (r_flush_count != 16'hFFFF))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign halt        = (r_state == HALTED);
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
